decode_unit: RTL and testbench
==============================

DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 EXC_RI, default 5'd10, exception code substituted for a reserved instruction.
REQ-002 Clk  in  1  sole clock; rising edge; asynchronous active-low reset Reset.
REQ-003 Reset  in  1  asynchronous, active-low; clears all registered state.
REQ-004 Instr  in  32  D-stage instruction.
REQ-005 A  in  32  forwarded rs value.
REQ-006 B  in  32  forwarded rt value.
REQ-007 ExcCodeIn  in  5  exception code carried in from F.
REQ-008 En  in  1  pipeline advance (0 = stall).
REQ-009 Clr  in  1  flush of the E bundle.
REQ-010 PCSrc  out  2  next-PC source: 0 PC+4, 1 NPC, 2 register (rs), 3 EPC.
REQ-011 NPCOp  out  1  0 branch target, 1 j/jal target.
REQ-012 Imm32  out  32  extended immediate.
REQ-013 A3  out  5  destination register.
REQ-014 GenD  out  1  D stage produces the PC+8 write data (jal, jalr).
REQ-015 D1Use / D2Use  out  1 each  rs / rt consumed in D (forward/stall request).
REQ-016 BD  out  1  current instruction is a branch or jump.
REQ-017 ExcCode  out  5  combinational exception code.
REQ-018 InSlot  out  1  current D instruction is in a delay slot.
REQ-019 Imm32E / A3E / ExcCodeE / BDE  out  32/5/5/1  registered E bundle; BDE = InSlot.

Function
REQ-020 Comparator: Equal = (A==B); LTZ = A[31]; EQZ = (A==0); all signed on 32 bits.
REQ-021 Extension: zero-extend for andi/ori/xori; imm<<16 for lui; sign-extend for all other instructions.
REQ-022 A3 selects rd for R-type ALU/shift instructions, mfhi, mflo and jalr.
REQ-023 A3 selects rt for addi, addiu, slti, sltiu, andi, ori, xori, lui, loads (lb, lbu, lh, lhu, lw) and mfc0.
REQ-024 A3 = 31 for jal.
REQ-025 A3 = 0 for stores, branches, j, jr, mult/multu/div/divu, mthi/mtlo, mtc0, eret and RI.
REQ-026 Branch condition per opcode: beq Equal; bne !Equal; blez LTZ|EQZ; bgtz !LTZ&!EQZ; bltz (op 1, rt 0) LTZ; bgez (op 1, rt 1) !LTZ.
REQ-027 Branch outputs: PCSrc=1 if taken, else 0; NPCOp=0; BD=1.
REQ-028 j/jal: PCSrc=1, NPCOp=1, BD=1.
REQ-029 jr/jalr: PCSrc=2, BD=1.
REQ-030 eret (op 0x10, rs 0x10, funct 0x18): PCSrc=3, BD=0.
REQ-031 D1Use=1 for all branches, jr and jalr; D2Use=1 only for beq and bne.
REQ-032 RI=1 for any encoding not listed above.
REQ-033 For RI: every control output is 0; ExcCode = EXC_RI if ExcCodeIn==0, else ExcCode = ExcCodeIn (earlier code wins).
REQ-034 Decode outputs are purely combinational, with zero latency.
REQ-035 InSlot register: on a clock edge with En=1, loads BD; with En=0, holds its value.
REQ-036 E bundle register: on a clock edge with Clr=1, loads 0 (Clr wins over En); with En=1, loads Imm32/A3/ExcCode/InSlot; otherwise holds.

Reset
REQ-037 Reset=0 immediately forces InSlot, Imm32E, A3E, ExcCodeE and BDE to 0, independent of Clk.
REQ-038 The first Clk edge after Reset deassertion behaves per REQ-035/036.

Configuration
REQ-039 With DECODE_SIGNED_BRANCH_EN defined, blez, bgtz, bltz and bgez decode per REQ-026.
REQ-040 Without DECODE_SIGNED_BRANCH_EN, blez, bgtz, bltz and bgez decode as RI; beq and bne are unaffected.

Verification
REQ-041 beq (0x1085FFFF), A=B=5 -> PCSrc=1, NPCOp=0, Imm32=0xFFFFFFFF, BD=1, D1Use=1, D2Use=1.
REQ-042 jal 0x0C000010 -> PCSrc=1, NPCOp=1, A3=31, GenD=1; next En edge: InSlot=1.
REQ-043 bltz, A=0x80000000 -> PCSrc=1; A=0 -> PCSrc=0; with the macro undefined -> RI path, ExcCode=10.
REQ-044 Instr=0xFC000000, ExcCodeIn=0 -> ExcCode=10; ExcCodeIn=4 -> ExcCode=4.
REQ-045 lui 0x3C011234 -> Imm32=0x12340000, A3=1; ori 0x3421FFFF -> Imm32=0x0000FFFF.
REQ-046 Clr=1 and En=1 on the same edge -> E bundle=0; Reset pulsed mid-cycle -> all registered outputs 0 at once.

Source files
------------

// File: rtl/decode_unit_if.sv
// D-stage decode bundle: instruction/operands in, decode controls and registered E bundle out.
// master = pipeline side driving the D-stage inputs, slave = decode_unit.
interface decode_unit_if;
  logic [31:0] instr;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  exc_code_in;
  logic        en;
  logic        clr;

  logic [1:0]  pc_src;
  logic        npc_op;
  logic [31:0] imm32;
  logic [4:0]  a3;
  logic        gen_d;
  logic        d1_use;
  logic        d2_use;
  logic        bd;
  logic [4:0]  exc_code;
  logic        in_slot;

  logic [31:0] imm32_e;
  logic [4:0]  a3_e;
  logic [4:0]  exc_code_e;
  logic        bd_e;

  modport master (
    output instr, a, b, exc_code_in, en, clr,
    input  pc_src, npc_op, imm32, a3, gen_d, d1_use, d2_use, bd, exc_code, in_slot,
    input  imm32_e, a3_e, exc_code_e, bd_e
  );

  modport slave (
    input  instr, a, b, exc_code_in, en, clr,
    output pc_src, npc_op, imm32, a3, gen_d, d1_use, d2_use, bd, exc_code, in_slot,
    output imm32_e, a3_e, exc_code_e, bd_e
  );
endinterface

// File: rtl/decode_unit.sv
// MIPS D-stage decoder: branch comparator, immediate extension, destination select, delay-slot flag and E-stage bundle.
// Optional macro DECODE_SIGNED_BRANCH_EN enables blez/bgtz/bltz/bgez; without it those decode as reserved.
module decode_unit #(
  parameter logic [4:0] EXC_RI = 5'd10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  decode_unit_if.slave io_dec
);

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_e;
  typedef enum logic [1:0] {A3_NONE, A3_RD, A3_RT, A3_RA} a3_sel_e;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;

  logic        w_equal;
  logic        w_ltz;
  logic        w_eqz;

  logic        w_ri;
  logic [1:0]  w_dec_pc_src;
  logic        w_dec_npc_op;
  logic        w_dec_gen_d;
  logic        w_dec_d1_use;
  logic        w_dec_d2_use;
  logic        w_dec_bd;
  ext_e        w_dec_ext;
  a3_sel_e     w_dec_a3_sel;

  logic [1:0]  w_pc_src;
  logic        w_npc_op;
  logic [31:0] w_imm32;
  logic [4:0]  w_a3;
  logic        w_gen_d;
  logic        w_d1_use;
  logic        w_d2_use;
  logic        w_bd;
  logic [4:0]  w_exc_code;

  logic        r_in_slot;
  logic [31:0] r_imm32_e;
  logic [4:0]  r_a3_e;
  logic [4:0]  r_exc_code_e;
  logic        r_bd_e;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_e mode);
    logic [31:0] res;
    case (mode)
      EXT_ZERO: res = {16'd0, imm};
      EXT_LUI:  res = {imm, 16'd0};
      default:  res = {{16{imm[15]}}, imm};
    endcase
    return res;
  endfunction

  function automatic logic [4:0] pick_a3(input a3_sel_e sel, input logic [4:0] rd, input logic [4:0] rt);
    logic [4:0] res;
    case (sel)
      A3_RD:   res = rd;
      A3_RT:   res = rt;
      A3_RA:   res = 5'd31;
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  assign w_op    = io_dec.instr[31:26];
  assign w_rs    = io_dec.instr[25:21];
  assign w_rt    = io_dec.instr[20:16];
  assign w_rd    = io_dec.instr[15:11];
  assign w_funct = io_dec.instr[5:0];
  assign w_imm   = io_dec.instr[15:0];

  assign w_equal = (io_dec.a == io_dec.b);
  assign w_ltz   = io_dec.a[31];
  assign w_eqz   = (io_dec.a == 32'd0);

  // Raw decode: classify the encoding and flag anything not recognised as reserved.
  always_comb begin
    w_ri         = 1'b0;
    w_dec_pc_src = 2'd0;
    w_dec_npc_op = 1'b0;
    w_dec_gen_d  = 1'b0;
    w_dec_d1_use = 1'b0;
    w_dec_d2_use = 1'b0;
    w_dec_bd     = 1'b0;
    w_dec_ext    = EXT_SIGN;
    w_dec_a3_sel = A3_NONE;
    case (w_op)
      6'h00: begin
        case (w_funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h10, 6'h12,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: w_dec_a3_sel = A3_RD;
          6'h08: begin
            w_dec_pc_src = 2'd2;
            w_dec_bd     = 1'b1;
            w_dec_d1_use = 1'b1;
          end
          6'h09: begin
            w_dec_pc_src = 2'd2;
            w_dec_bd     = 1'b1;
            w_dec_d1_use = 1'b1;
            w_dec_gen_d  = 1'b1;
            w_dec_a3_sel = A3_RD;
          end
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: w_dec_a3_sel = A3_NONE;
          default: w_ri = 1'b1;
        endcase
      end
      6'h01: begin
`ifdef DECODE_SIGNED_BRANCH_EN
        if (w_rt == 5'd0) begin
          w_dec_bd     = 1'b1;
          w_dec_d1_use = 1'b1;
          w_dec_pc_src = w_ltz ? 2'd1 : 2'd0;
        end else if (w_rt == 5'd1) begin
          w_dec_bd     = 1'b1;
          w_dec_d1_use = 1'b1;
          w_dec_pc_src = (!w_ltz) ? 2'd1 : 2'd0;
        end else begin
          w_ri = 1'b1;
        end
`else
        w_ri = 1'b1;
`endif
      end
      6'h02: begin
        w_dec_pc_src = 2'd1;
        w_dec_npc_op = 1'b1;
        w_dec_bd     = 1'b1;
      end
      6'h03: begin
        w_dec_pc_src = 2'd1;
        w_dec_npc_op = 1'b1;
        w_dec_bd     = 1'b1;
        w_dec_gen_d  = 1'b1;
        w_dec_a3_sel = A3_RA;
      end
      6'h04, 6'h05: begin
        w_dec_bd     = 1'b1;
        w_dec_d1_use = 1'b1;
        w_dec_d2_use = 1'b1;
        w_dec_pc_src = ((w_op == 6'h04) == w_equal) ? 2'd1 : 2'd0;
      end
      6'h06, 6'h07: begin
`ifdef DECODE_SIGNED_BRANCH_EN
        w_dec_bd     = 1'b1;
        w_dec_d1_use = 1'b1;
        if (w_op == 6'h06) begin
          w_dec_pc_src = (w_ltz | w_eqz) ? 2'd1 : 2'd0;
        end else begin
          w_dec_pc_src = (!w_ltz & !w_eqz) ? 2'd1 : 2'd0;
        end
`else
        w_ri = 1'b1;
`endif
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: w_dec_a3_sel = A3_RT;
      6'h0C, 6'h0D, 6'h0E: begin
        w_dec_a3_sel = A3_RT;
        w_dec_ext    = EXT_ZERO;
      end
      6'h0F: begin
        w_dec_a3_sel = A3_RT;
        w_dec_ext    = EXT_LUI;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_dec_a3_sel = A3_RT;
      6'h28, 6'h29, 6'h2B: w_dec_a3_sel = A3_NONE;
      6'h10: begin
        // COP0: mfc0 writes rt, mtc0 writes nothing, eret returns through EPC.
        if (w_rs == 5'd0) begin
          w_dec_a3_sel = A3_RT;
        end else if (w_rs == 5'd4) begin
          w_dec_a3_sel = A3_NONE;
        end else if ((w_rs == 5'h10) && (w_funct == 6'h18)) begin
          w_dec_pc_src = 2'd3;
        end else begin
          w_ri = 1'b1;
        end
      end
      default: w_ri = 1'b1;
    endcase
  end

  // Reserved encodings silence every control and raise EXC_RI unless an earlier stage already faulted.
  always_comb begin
    if (w_ri) begin
      w_pc_src   = 2'd0;
      w_npc_op   = 1'b0;
      w_imm32    = 32'd0;
      w_a3       = 5'd0;
      w_gen_d    = 1'b0;
      w_d1_use   = 1'b0;
      w_d2_use   = 1'b0;
      w_bd       = 1'b0;
      w_exc_code = (io_dec.exc_code_in == 5'd0) ? EXC_RI : io_dec.exc_code_in;
    end else begin
      w_pc_src   = w_dec_pc_src;
      w_npc_op   = w_dec_npc_op;
      w_imm32    = extend_imm(w_imm, w_dec_ext);
      w_a3       = pick_a3(w_dec_a3_sel, w_rd, w_rt);
      w_gen_d    = w_dec_gen_d;
      w_d1_use   = w_dec_d1_use;
      w_d2_use   = w_dec_d2_use;
      w_bd       = w_dec_bd;
      w_exc_code = io_dec.exc_code_in;
    end
  end

  // Delay-slot flag and E-stage bundle; flush beats advance, and BDE captures the slot flag of the departing instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_slot    <= 1'b0;
      r_imm32_e    <= 32'd0;
      r_a3_e       <= 5'd0;
      r_exc_code_e <= 5'd0;
      r_bd_e       <= 1'b0;
    end else begin
      if (io_dec.en) begin
        r_in_slot <= w_bd;
      end
      if (io_dec.clr) begin
        r_imm32_e    <= 32'd0;
        r_a3_e       <= 5'd0;
        r_exc_code_e <= 5'd0;
        r_bd_e       <= 1'b0;
      end else if (io_dec.en) begin
        r_imm32_e    <= w_imm32;
        r_a3_e       <= w_a3;
        r_exc_code_e <= w_exc_code;
        r_bd_e       <= r_in_slot;
      end
    end
  end

  assign io_dec.pc_src     = w_pc_src;
  assign io_dec.npc_op     = w_npc_op;
  assign io_dec.imm32      = w_imm32;
  assign io_dec.a3         = w_a3;
  assign io_dec.gen_d      = w_gen_d;
  assign io_dec.d1_use     = w_d1_use;
  assign io_dec.d2_use     = w_d2_use;
  assign io_dec.bd         = w_bd;
  assign io_dec.exc_code   = w_exc_code;
  assign io_dec.in_slot    = r_in_slot;
  assign io_dec.imm32_e    = r_imm32_e;
  assign io_dec.a3_e       = r_a3_e;
  assign io_dec.exc_code_e = r_exc_code_e;
  assign io_dec.bd_e       = r_bd_e;

endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: directed vectors plus randomized decode and pipeline traffic
// checked against an instruction-level reference model.
module tb_decode_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  decode_unit_if dif();
  decode_unit #(.EXC_RI(5'd10)) dut (.i_clk(clk), .i_rst_n(rst_n), .io_dec(dif));

  always #5 clk = ~clk;

`ifdef DECODE_SIGNED_BRANCH_EN
  localparam bit SIGNED_BR = 1'b1;
`else
  localparam bit SIGNED_BR = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  pc_src;
    logic        npc_op;
    logic [31:0] imm32;
    logic [4:0]  a3;
    logic        gen_d;
    logic        d1;
    logic        d2;
    logic        bd;
    logic [4:0]  exc;
  } dec_t;

  logic        m_slot;
  logic [31:0] m_imm;
  logic [4:0]  m_a3;
  logic [4:0]  m_exc;
  logic        m_bde;

  // Reference decode, written per mnemonic using signed arithmetic for branch conditions.
  function automatic dec_t ref_dec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] eci);
    dec_t d;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic signed [31:0] sa;
    bit legal, is_br, taken;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0]; imm = ins[15:0];
    sa = a; d = '0; legal = 1'b1; is_br = 1'b0; taken = 1'b0;
    case (op)
      6'd0: begin
        if (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd16, 6'd18, [6'd32:6'd39], 6'd42, 6'd43}) d.a3 = rd;
        else if (fn == 6'd8) begin d.pc_src = 2'd2; d.bd = 1'b1; d.d1 = 1'b1; end
        else if (fn == 6'd9) begin d.pc_src = 2'd2; d.bd = 1'b1; d.d1 = 1'b1; d.gen_d = 1'b1; d.a3 = rd; end
        else if (!(fn inside {6'd17, 6'd19, [6'd24:6'd27]})) legal = 1'b0;
      end
      6'd1: begin
        if (SIGNED_BR && rt == 5'd0) begin is_br = 1'b1; taken = (sa < 0); end
        else if (SIGNED_BR && rt == 5'd1) begin is_br = 1'b1; taken = (sa >= 0); end
        else legal = 1'b0;
      end
      6'd2: begin d.pc_src = 2'd1; d.npc_op = 1'b1; d.bd = 1'b1; end
      6'd3: begin d.pc_src = 2'd1; d.npc_op = 1'b1; d.bd = 1'b1; d.gen_d = 1'b1; d.a3 = 5'd31; end
      6'd4: begin is_br = 1'b1; taken = (a == b); d.d2 = 1'b1; end
      6'd5: begin is_br = 1'b1; taken = (a != b); d.d2 = 1'b1; end
      6'd6: begin is_br = SIGNED_BR; legal = SIGNED_BR; taken = (sa <= 0); end
      6'd7: begin is_br = SIGNED_BR; legal = SIGNED_BR; taken = (sa > 0); end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: d.a3 = rt;
      6'd32, 6'd33, 6'd35, 6'd36, 6'd37: d.a3 = rt;
      6'd40, 6'd41, 6'd43: d.a3 = 5'd0;
      6'd16: begin
        if (rs == 5'd0) d.a3 = rt;
        else if (rs == 5'd4) d.a3 = 5'd0;
        else if (rs == 5'd16 && fn == 6'd24) d.pc_src = 2'd3;
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (is_br) begin d.bd = 1'b1; d.d1 = 1'b1; d.pc_src = taken ? 2'd1 : 2'd0; end
    if (op inside {6'd12, 6'd13, 6'd14}) d.imm32 = {16'h0000, imm};
    else if (op == 6'd15) d.imm32 = {imm, 16'h0000};
    else d.imm32 = {{16{imm[15]}}, imm};
    d.exc = eci;
    if (!legal) begin
      d = '0;
      d.exc = (eci == 5'd0) ? 5'd10 : eci;
    end
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0] op;
    w = $urandom;
    case ($urandom_range(0, 11))
      0, 1:    op = 6'h00;
      2:       op = 6'h01;
      3:       op = 6'($urandom_range(2, 7));
      4:       op = 6'($urandom_range(8, 15));
      5:       op = 6'h10;
      6:       op = 6'h20 + 6'($urandom_range(0, 11));
      7:       op = 6'h04;
      8:       op = 6'h05;
      default: op = w[31:26];
    endcase
    w[31:26] = op;
    if (op == 6'h01) w[20:16] = 5'($urandom_range(0, 2));
    if (op == 6'h10) begin
      case ($urandom_range(0, 3))
        0:       w[25:21] = 5'd0;
        1:       w[25:21] = 5'd4;
        2:       begin w[25:21] = 5'h10; w[5:0] = 6'h18; end
        default: w[25:21] = w[25:21];
      endcase
    end
    return w;
  endfunction

  task automatic drive_operands();
    dif.a = $urandom;
    case ($urandom_range(0, 5))
      0:       dif.a = 32'd0;
      1:       dif.a = 32'h8000_0000;
      default: dif.a = dif.a;
    endcase
    dif.b = ($urandom_range(0, 2) == 0) ? dif.a : 32'($urandom);
  endtask

  // Apply en/clr across one rising edge and advance the model of the registered state.
  task automatic clock_edge(input logic en_v, input logic clr_v);
    dec_t d;
    dif.en = en_v;
    dif.clr = clr_v;
    d = ref_dec(dif.instr, dif.a, dif.b, dif.exc_code_in);
    @(posedge clk);
    #1;
    if (clr_v) begin
      m_imm = 32'd0; m_a3 = 5'd0; m_exc = 5'd0; m_bde = 1'b0;
    end else if (en_v) begin
      m_imm = d.imm32; m_a3 = d.a3; m_exc = d.exc; m_bde = m_slot;
    end
    if (en_v) m_slot = d.bd;
    dif.en = 1'b0;
    dif.clr = 1'b0;
  endtask

  task automatic test_reset();
    dif.instr = 32'h0C00_0010; dif.a = 32'd0; dif.b = 32'd0; dif.exc_code_in = 5'd7;
    dif.en = 1'b1; dif.clr = 1'b0;
    #3;
    n_cmp++;
    if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== 44'd0) begin
      n_err++; $display("FAIL reset_state got %h exp 0", {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== 44'd0) begin
      n_err++; $display("FAIL reset_hold_on_edge got %h exp 0", {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e});
    end
    @(negedge clk);
    dif.en = 1'b0;
    rst_n = 1'b1;
    m_slot = 1'b0; m_imm = 32'd0; m_a3 = 5'd0; m_exc = 5'd0; m_bde = 1'b0;
  endtask

  task automatic test_directed();
    dif.exc_code_in = 5'd0;
    dif.instr = 32'h1085_FFFF; dif.a = 32'd5; dif.b = 32'd5; #1;
    n_cmp++;
    if ({dif.pc_src, dif.npc_op, dif.imm32, dif.bd, dif.d1_use, dif.d2_use} !== {2'd1, 1'b0, 32'hFFFF_FFFF, 3'b111}) begin
      n_err++; $display("FAIL beq_taken got %h exp %h", {dif.pc_src, dif.npc_op, dif.imm32, dif.bd, dif.d1_use, dif.d2_use},
                        {2'd1, 1'b0, 32'hFFFF_FFFF, 3'b111});
    end
    dif.b = 32'd6; #1;
    n_cmp++;
    if (dif.pc_src !== 2'd0) begin n_err++; $display("FAIL beq_not_taken got %0d exp 0", dif.pc_src); end

    dif.instr = 32'h0C00_0010; #1;
    n_cmp++;
    if ({dif.pc_src, dif.npc_op, dif.a3, dif.gen_d} !== {2'd1, 1'b1, 5'd31, 1'b1}) begin
      n_err++; $display("FAIL jal_decode got %h exp %h", {dif.pc_src, dif.npc_op, dif.a3, dif.gen_d}, {2'd1, 1'b1, 5'd31, 1'b1});
    end
    clock_edge(1'b1, 1'b0);
    n_cmp++;
    if (dif.in_slot !== 1'b1) begin n_err++; $display("FAIL jal_in_slot got %b exp 1", dif.in_slot); end

    dif.instr = 32'h0420_0003; dif.a = 32'h8000_0000; #1;
    n_cmp++;
`ifdef DECODE_SIGNED_BRANCH_EN
    if ({dif.pc_src, dif.bd, dif.exc_code} !== {2'd1, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL bltz_neg got %h exp %h", {dif.pc_src, dif.bd, dif.exc_code}, {2'd1, 1'b1, 5'd0});
    end
`else
    if ({dif.pc_src, dif.bd, dif.d1_use, dif.exc_code} !== {2'd0, 1'b0, 1'b0, 5'd10}) begin
      n_err++; $display("FAIL bltz_ri got %h exp %h", {dif.pc_src, dif.bd, dif.d1_use, dif.exc_code}, {2'd0, 1'b0, 1'b0, 5'd10});
    end
`endif
    dif.a = 32'd0; #1;
    n_cmp++;
    if (dif.pc_src !== 2'd0) begin n_err++; $display("FAIL bltz_zero got %0d exp 0", dif.pc_src); end

    dif.instr = 32'hFC00_0000; #1;
    n_cmp++;
    if ({dif.exc_code, dif.pc_src, dif.a3, dif.imm32} !== {5'd10, 2'd0, 5'd0, 32'd0}) begin
      n_err++; $display("FAIL ri_default got exc %0d pc_src %0d a3 %0d exp 10/0/0", dif.exc_code, dif.pc_src, dif.a3);
    end
    dif.exc_code_in = 5'd4; #1;
    n_cmp++;
    if (dif.exc_code !== 5'd4) begin n_err++; $display("FAIL ri_earlier_wins got %0d exp 4", dif.exc_code); end
    dif.exc_code_in = 5'd0;

    dif.instr = 32'h3C01_1234; #1;
    n_cmp++;
    if ({dif.imm32, dif.a3} !== {32'h1234_0000, 5'd1}) begin
      n_err++; $display("FAIL lui got imm %h a3 %0d exp 12340000/1", dif.imm32, dif.a3);
    end
    dif.instr = 32'h3421_FFFF; #1;
    n_cmp++;
    if ({dif.imm32, dif.a3} !== {32'h0000_FFFF, 5'd1}) begin
      n_err++; $display("FAIL ori got imm %h a3 %0d exp 0000ffff/1", dif.imm32, dif.a3);
    end
    dif.instr = 32'h4200_0018; #1;
    n_cmp++;
    if ({dif.pc_src, dif.bd, dif.a3} !== {2'd3, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL eret got pc_src %0d bd %b a3 %0d exp 3/0/0", dif.pc_src, dif.bd, dif.a3);
    end
    dif.instr = 32'h03E0_F809; #1;
    n_cmp++;
    if ({dif.pc_src, dif.gen_d, dif.d1_use, dif.d2_use, dif.a3} !== {2'd2, 1'b1, 1'b1, 1'b0, 5'd31}) begin
      n_err++; $display("FAIL jalr got pc_src %0d gen_d %b a3 %0d exp 2/1/31", dif.pc_src, dif.gen_d, dif.a3);
    end
  endtask

  task automatic test_random_decode();
    dec_t exp_d, got;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dif.instr = rand_instr();
      drive_operands();
      dif.exc_code_in = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      #1;
      exp_d = ref_dec(dif.instr, dif.a, dif.b, dif.exc_code_in);
      got = {dif.pc_src, dif.npc_op, dif.imm32, dif.a3, dif.gen_d, dif.d1_use, dif.d2_use, dif.bd, dif.exc_code};
      n_cmp++;
      if (got !== exp_d) begin
        n_err++; $display("FAIL rand_decode instr=%h a=%h b=%h got %h exp %h", dif.instr, dif.a, dif.b, got, exp_d);
      end
    end
  endtask

  task automatic test_pipeline();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dif.instr = rand_instr();
      drive_operands();
      dif.exc_code_in = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      clock_edge(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 5) == 0));
      n_cmp++;
      if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== {m_slot, m_imm, m_a3, m_exc, m_bde}) begin
        n_err++; $display("FAIL pipe_regs cycle %0d got %h exp %h", i, {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e},
                          {m_slot, m_imm, m_a3, m_exc, m_bde});
      end
    end
  endtask

  task automatic test_clr_en();
    @(negedge clk);
    dif.instr = 32'h3C01_1234; dif.exc_code_in = 5'd0;
    clock_edge(1'b1, 1'b0);
    n_cmp++;
    if ({dif.imm32_e, dif.a3_e, dif.exc_code_e} !== {32'h1234_0000, 5'd1, 5'd0}) begin
      n_err++; $display("FAIL e_load got %h exp %h", {dif.imm32_e, dif.a3_e, dif.exc_code_e}, {32'h1234_0000, 5'd1, 5'd0});
    end
    dif.instr = 32'h3421_FFFF;
    clock_edge(1'b0, 1'b0);
    n_cmp++;
    if ({dif.imm32_e, dif.a3_e} !== {32'h1234_0000, 5'd1}) begin
      n_err++; $display("FAIL e_stall_hold got %h exp %h", {dif.imm32_e, dif.a3_e}, {32'h1234_0000, 5'd1});
    end
    clock_edge(1'b1, 1'b1);
    n_cmp++;
    if ({dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e, dif.in_slot} !== 44'd0) begin
      n_err++; $display("FAIL clr_beats_en got %h exp 0", {dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e, dif.in_slot});
    end
    clock_edge(1'b1, 1'b0);
    clock_edge(1'b0, 1'b1);
    n_cmp++;
    if ({dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== 43'd0) begin
      n_err++; $display("FAIL clr_no_en got %h exp 0", {dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    dif.instr = 32'h0C00_0010; dif.a = 32'd0; dif.b = 32'd0; dif.exc_code_in = 5'd3;
    clock_edge(1'b1, 1'b0);
    clock_edge(1'b1, 1'b0);
    n_cmp++;
    if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== {1'b1, 32'h0000_0010, 5'd31, 5'd3, 1'b1}) begin
      n_err++; $display("FAIL pre_reset_load got %h exp %h", {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e},
                        {1'b1, 32'h0000_0010, 5'd31, 5'd3, 1'b1});
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== 44'd0) begin
      n_err++; $display("FAIL async_reset got %h exp 0", {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e});
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_slot = 1'b0; m_imm = 32'd0; m_a3 = 5'd0; m_exc = 5'd0; m_bde = 1'b0;
    clock_edge(1'b1, 1'b0);
    n_cmp++;
    if ({dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e} !== {m_slot, m_imm, m_a3, m_exc, m_bde}) begin
      n_err++; $display("FAIL first_edge_after_reset got %h exp %h", {dif.in_slot, dif.imm32_e, dif.a3_e, dif.exc_code_e, dif.bd_e},
                        {m_slot, m_imm, m_a3, m_exc, m_bde});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_decode();
    test_pipeline();
    test_clr_en();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
